mem_arbiter: RTL

Shares the core's single memory bus between two requesters: the core port (instruction fetch and load/store, driven by the control block's `mem_rden`/`mem_wren` and returning `done`) and an auxiliary port (debug/loader). It sits between the core datapath and the memory, latches one transaction at a time, holds the bus request until the memory acknowledges, and returns a one-cycle `done` pulse with read data to the granted requester. Fixed priority to the core, with a starvation guard for the auxiliary port.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic ARB_CORE = 1'b0;
  localparam logic ARB_AUX  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory bus between the core and an auxiliary port: one latched
// transaction at a time, core priority with a starvation guard for aux.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_rden,
  input  logic            c_wren,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  input  logic [DW/8-1:0] c_wstrb,
  output logic [DW-1:0]   c_rdata,
  output logic            c_done,
  input  logic            a_rden,
  input  logic            a_wren,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic [DW/8-1:0] a_wstrb,
  output logic [DW-1:0]   a_rdata,
  output logic            a_done,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t      state_q;
  logic            win_q;
  logic            m_req_q;
  logic            m_we_q;
  logic [AW-1:0]   m_addr_q;
  logic [DW-1:0]   m_wdata_q;
  logic [DW/8-1:0] m_wstrb_q;
  logic [DW-1:0]   rdata_q;
  logic            c_done_q;
  logic            a_done_q;
  logic [3:0]      starve_q;

  logic            c_pend;
  logic            a_pend;
  logic            win_d;
  logic [3:0]      starve_d;

  always_comb begin
    c_pend   = c_rden | c_wren;
    a_pend   = a_rden | a_wren;
    win_d    = ARB_AUX;
    starve_d = starve_q;
    if (a_pend && (starve_q == LIMIT)) begin
      win_d = ARB_AUX;
    end else if (c_pend) begin
      win_d = ARB_CORE;
    end
    // The counter only tracks core grants that made a pending aux wait.
    if (!a_pend || (win_d == ARB_AUX)) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      win_q     <= ARB_CORE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      rdata_q   <= '0;
      c_done_q  <= 1'b0;
      a_done_q  <= 1'b0;
      starve_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          c_done_q <= 1'b0;
          a_done_q <= 1'b0;
          starve_q <= starve_d;
          if (c_pend || a_pend) begin
            win_q   <= win_d;
            m_req_q <= 1'b1;
            state_q <= ARB_BUSY;
            if (win_d == ARB_AUX) begin
              m_we_q    <= a_wren;
              m_addr_q  <= a_addr;
              m_wdata_q <= a_wdata;
              m_wstrb_q <= a_wstrb;
            end else begin
              m_we_q    <= c_wren;
              m_addr_q  <= c_addr;
              m_wdata_q <= c_wdata;
              m_wstrb_q <= c_wstrb;
            end
          end
        end
        ARB_BUSY: begin
          if (m_ack) begin
            m_req_q  <= 1'b0;
            c_done_q <= (win_q == ARB_CORE);
            a_done_q <= (win_q == ARB_AUX);
            state_q  <= ARB_RESP;
            if (!m_we_q) begin
              rdata_q <= m_rdata;
            end
          end
        end
        ARB_RESP: begin
          c_done_q <= 1'b0;
          a_done_q <= 1'b0;
          state_q  <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign c_rdata = rdata_q;
  assign a_rdata = rdata_q;
  assign c_done  = c_done_q;
  assign a_done  = a_done_q;

endmodule
